// File: rtl/diff_pkg.sv
// Shared definitions for the differential transmit path: code width and the
// transmit-queue sequencing states. Transceiver code paths size themselves from CODE_W.
package diff_pkg;

    localparam int CODE_W = 26;

    typedef enum logic [2:0] {
        Q_IDLE,
        Q_ISSUE,
        Q_WAIT_START,
        Q_WAIT_DONE,
        Q_GAP
    } queue_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with valid/ready push, pop strobe and a continuously visible head.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module sync_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   srst_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   push_valid_i,
    output logic                   push_ready_o,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push;
    logic             pop;

    // Full and empty come from the occupancy count, not pointer comparison.
    assign push_ready_o = (count_q != FULL_COUNT);
    assign push         = push_valid_i && push_ready_o;
    assign pop          = pop_i && (count_q != '0);
    assign head_o       = mem_q[rd_ptr_q];
    assign count_o      = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/diff_tx_queue.sv
// Transmit queue in front of a differential transceiver: buffers codes, issues one
// trigger per code, waits for the link to start and finish, then enforces an idle gap.
module diff_tx_queue
    import diff_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int GAP_CYCLES    = 16,
    parameter int START_TIMEOUT = 4096
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [CODE_W-1:0]      data_in,
    input  logic                   valid_in,
    output logic                   ready_out,
    input  logic                   io_sel_in,
    output logic                   trigger_out,
    output logic [CODE_W-1:0]      data_out,
    output logic [$clog2(DEPTH):0] count_out,
    output logic                   timeout_out
);

    localparam int TMR_W = $clog2(max_int(START_TIMEOUT, GAP_CYCLES) + 1);
    localparam logic [TMR_W-1:0] START_LAST = TMR_W'(START_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP_CYCLES - 1);

    queue_state_e             state_q;
    logic [TMR_W-1:0]         timer_q;
    logic                     trigger_q;
    logic                     timeout_q;
    logic                     pop;
    logic [$clog2(DEPTH):0]   fifo_count;

    sync_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk_in),
        .srst_i       (rst_in),
        .push_data_i  (data_in),
        .push_valid_i (valid_in),
        .push_ready_o (ready_out),
        .pop_i        (pop),
        .head_o       (data_out),
        .count_o      (fifo_count)
    );

    // The head leaves the queue only when the link finishes or never starts.
    assign pop = !io_sel_in &&
                 ((state_q == Q_WAIT_DONE) ||
                  ((state_q == Q_WAIT_START) && (timer_q == START_LAST)));

    assign count_out   = fifo_count;
    assign trigger_out = trigger_q;
    assign timeout_out = timeout_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= Q_IDLE;
            timer_q   <= '0;
            trigger_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            trigger_q <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                Q_IDLE: begin
                    // Foreign link activity keeps us parked here.
                    if ((fifo_count != '0) && !io_sel_in) begin
                        state_q <= Q_ISSUE;
                    end
                end
                Q_ISSUE: begin
                    trigger_q <= 1'b1;
                    timer_q   <= '0;
                    state_q   <= Q_WAIT_START;
                end
                Q_WAIT_START: begin
                    if (io_sel_in) begin
                        state_q <= Q_WAIT_DONE;
                    end else if (timer_q == START_LAST) begin
                        timeout_q <= 1'b1;
                        timer_q   <= '0;
                        state_q   <= Q_GAP;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                Q_WAIT_DONE: begin
                    if (!io_sel_in) begin
                        timer_q <= '0;
                        state_q <= Q_GAP;
                    end
                end
                Q_GAP: begin
                    if (timer_q == GAP_LAST) begin
                        state_q <= Q_IDLE;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                default: state_q <= Q_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_diff_tx_queue.sv
// Bench for diff_tx_queue: timestamp-based behavioural model checked every cycle,
// plus directed scenarios with hand-computed latencies and data.
module tb_diff_tx_queue;

    localparam int DEPTH = 8;
    localparam int GAP   = 16;
    localparam int ST    = 64;

    logic        clk       = 1'b0;
    logic        rst_in    = 1'b1;
    logic        valid_in  = 1'b0;
    logic [25:0] data_in   = '0;
    logic        resp_sel  = 1'b0;
    logic        force_sel = 1'b0;
    logic        io_sel;
    logic        ready_out;
    logic        trigger_out;
    logic [25:0] data_out;
    logic [3:0]  count_out;
    logic        timeout_out;

    bit resp_en  = 1'b0;
    int resp_len = 10;

    int checks   = 0;
    int failures = 0;

    assign io_sel = resp_sel | force_sel;

    always #5 clk = ~clk;

    diff_tx_queue #(
        .DEPTH         (DEPTH),
        .GAP_CYCLES    (GAP),
        .START_TIMEOUT (ST)
    ) dut (
        .clk_in      (clk),
        .rst_in      (rst_in),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .io_sel_in   (io_sel),
        .trigger_out (trigger_out),
        .data_out    (data_out),
        .count_out   (count_out),
        .timeout_out (timeout_out)
    );

    // ---------------- behavioural model (edge timestamps + code queue)
    int          cyc       = 0;
    logic [25:0] mq[$];
    bit          m_busy    = 1'b0;
    bit          m_started = 1'b0;
    int          issue_at  = 0;
    int          idle_from = 0;
    int          rst_cyc   = 0;
    bit          exp_trig  = 1'b0;
    bit          exp_to    = 1'b0;
    int          exp_count = 0;
    logic [25:0] exp_head  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        int pre_size;
        bit do_pop;
        cyc++;
        exp_trig = 1'b0;
        exp_to   = 1'b0;
        do_pop   = 1'b0;
        pre_size = mq.size();
        if (rst_in) begin
            mq.delete();
            m_busy    = 1'b0;
            idle_from = cyc + 1;
            rst_cyc   = cyc;
        end else begin
            if (m_busy && cyc > issue_at) begin
                if (!m_started) begin
                    if (io_sel) m_started = 1'b1;
                    else if (cyc - issue_at == ST) begin
                        do_pop = 1'b1;
                        exp_to = 1'b1;
                    end
                end else if (!io_sel) begin
                    do_pop = 1'b1;
                end
                if (do_pop) begin
                    m_busy    = 1'b0;
                    idle_from = cyc + GAP + 1;
                end
            end else if (!m_busy && cyc >= idle_from && pre_size != 0 && !io_sel) begin
                m_busy    = 1'b1;
                m_started = 1'b0;
                issue_at  = cyc + 1;
            end
            if (m_busy && cyc == issue_at) exp_trig = 1'b1;
            if (do_pop) void'(mq.pop_front());
            if (valid_in && pre_size != DEPTH) mq.push_back(data_in);
        end
        exp_count = mq.size();
        exp_head  = (exp_count != 0) ? mq[0] : '0;
    end

    // ---------------- per-cycle comparison and trigger monitor
    int          trig_count = 0;
    int          last_trig  = -1000;
    logic [25:0] sent[$];

    always @(negedge clk) begin
        check("trigger_out", trigger_out, exp_trig);
        check("timeout_out", timeout_out, exp_to);
        check("count_out", count_out, exp_count);
        check("ready_out", ready_out, exp_count != DEPTH);
        if (exp_count != 0) check("data_out", data_out, exp_head);
        if (trigger_out === 1'b1) begin
            if (last_trig > rst_cyc) check("trig_spacing", (cyc - last_trig) >= GAP + 3, 1);
            last_trig = cyc;
            trig_count++;
            sent.push_back(data_out);
        end
    end

    // ---------------- transceiver stand-in: answers each trigger with a busy window
    always begin
        @(negedge clk);
        if (resp_en && trigger_out === 1'b1) begin
            resp_sel = 1'b1;
            repeat (resp_len) @(negedge clk);
            resp_sel = 1'b0;
        end
    end

    task automatic push(input logic [25:0] code);
        int n = 0;
        data_in  = code;
        valid_in = 1'b1;
        while (ready_out !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        valid_in = 1'b0;
        checks++;
        if (n >= 500) begin
            failures++;
            $display("FAIL push_wait actual=ready never high required=accept within 500 cycles");
        end
    endtask

    task automatic wait_trig(input int limit, output int n);
        n = 0;
        while (trigger_out !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (trigger_out !== 1'b1) begin
            failures++;
            $display("FAIL trig_wait actual=no trigger required=trigger within %0d cycles", limit);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((count_out !== 4'd0 || resp_sel) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            failures++;
            $display("FAIL drain_wait actual=count %0d required=0 within 3000 cycles", count_out);
        end
        repeat (GAP + 4) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=still running required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int acc;
        int pre_cnt;
        int tc0;
        bit pre_ready;
        bit seen_full_pop;
        logic [25:0] codes[9];
        codes = '{26'h000_0001, 26'h3FF_FFFE, 26'h155_5555, 26'h2AA_AAAA, 26'h012_3456,
                  26'h3ED_CBA9, 26'h100_0000, 26'h000_8000, 26'h2AB_CDEF};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_count", count_out, 0);
        check("rst_ready", ready_out, 1);
        check("rst_trigger", trigger_out, 0);
        check("rst_timeout", timeout_out, 0);
        rst_in = 1'b0;
        @(negedge clk);

        // Single code: trigger two edges after the push, link busy 40 cycles
        resp_en  = 1'b1;
        resp_len = 40;
        push(26'h2AB_CDEF);
        wait_trig(50, n);
        check("single_latency", n, 2);
        check("single_data", data_out, 26'h2AB_CDEF);
        repeat (30) @(negedge clk);
        check("single_inflight_count", count_out, 1);
        wait_drain();
        check("single_drained", count_out, 0);

        // Nine codes back-to-back into an 8-deep queue
        sent.delete();
        resp_len      = 10;
        acc           = 0;
        n             = 0;
        seen_full_pop = 1'b0;
        data_in       = codes[0];
        valid_in      = 1'b1;
        while (acc < 9 && n < 2000) begin
            pre_ready = ready_out;
            pre_cnt   = count_out;
            @(negedge clk);
            n++;
            if (pre_ready) begin
                acc++;
                if (acc == 8) begin
                    check("full_ready_low", ready_out, 0);
                    check("full_count", count_out, DEPTH);
                end
                if (acc < 9) data_in = codes[acc];
            end else if (pre_cnt == DEPTH && count_out != DEPTH) begin
                check("full_pop_count", count_out, DEPTH - 1);
                check("full_pop_ready", ready_out, 1);
                seen_full_pop = 1'b1;
            end
        end
        valid_in = 1'b0;
        check("burst_accepted", acc, 9);
        check("burst_full_pop_seen", seen_full_pop, 1);
        wait_drain();
        check("burst_sent_count", sent.size(), 9);
        for (int k = 0; k < 9; k++) begin
            if (k < sent.size()) check("burst_order", sent[k], codes[k]);
        end

        // Start timeout: link never answers the first trigger
        resp_en = 1'b0;
        push(26'h155_5555);
        push(26'h0FE_DCBA);
        wait_trig(20, n);
        check("to_head", data_out, 26'h155_5555);
        n = 0;
        while (timeout_out !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("to_latency", n, ST);
        check("to_count", count_out, 1);
        check("to_next_head", data_out, 26'h0FE_DCBA);
        resp_en  = 1'b1;
        resp_len = 8;
        wait_trig(100, n);
        check("to_retrigger_gap", n, GAP + 2);
        check("to_retrigger_data", data_out, 26'h0FE_DCBA);
        wait_drain();

        // Foreign link activity holds the queue until io_sel falls
        force_sel = 1'b1;
        tc0 = trig_count;
        push(26'h0A5_A5A5);
        push(26'h35A_5A5A);
        repeat (20) @(negedge clk);
        check("ext_no_trigger", trig_count - tc0, 0);
        check("ext_count", count_out, 2);
        force_sel = 1'b0;
        wait_trig(20, n);
        check("ext_release_latency", n, 2);
        check("ext_head", data_out, 26'h0A5_A5A5);
        wait_drain();

        // Reset in the middle of a transmission discards everything
        resp_len = 30;
        push(26'h111_1111);
        push(26'h222_2222);
        push(26'h333_3333);
        wait_trig(20, n);
        repeat (5) @(negedge clk);
        rst_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
        check("midrst_count", count_out, 0);
        check("midrst_trigger", trigger_out, 0);
        check("midrst_timeout", timeout_out, 0);
        check("midrst_ready", ready_out, 1);
        n = 0;
        while (resp_sel && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        push(26'h3C3_C3C3);
        wait_trig(20, n);
        check("post_rst_latency", n, 2);
        check("post_rst_data", data_out, 26'h3C3_C3C3);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
